// File: rtl/cnn_seq_pkg.sv
// -----------------------------------------------------------------------------
// cnn_seq_pkg
// Shared types and constants for the CNN stage sequencer.
//   STATE_W        width of the sequencer state encoding
//   CNT_W_DEFAULT  default width of the per-stage budget and cycle counter
//   seq_state_t    sequencer states: IDLE -> FLUSH -> RUN -> DONE -> IDLE
// -----------------------------------------------------------------------------
package cnn_seq_pkg;

   localparam int STATE_W       = 2;
   localparam int CNT_W_DEFAULT = 20;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/stage_cycle_counter.sv
// -----------------------------------------------------------------------------
// stage_cycle_counter
// Saturating cycle counter for the active stage, with budget and watchdog
// compares. Optional macro: SEQ_TIMEOUT_EN adds the watchdog compare output.
//   clk, reset      clock, asynchronous active-high reset
//   clear_i         restart counting from 0 on the next cycle
//   budget_i        cycle budget of the active stage (0 = no budget)
//   budget_hit_o    active stage is in its last budgeted cycle
//   timeout_hit_o   active stage is in its last allowed cycle (SEQ_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module stage_cycle_counter
   import cnn_seq_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT
`ifdef SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT = (1 << CNT_W) - 1
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] budget_i,
   output logic             budget_hit_o
`ifdef SEQ_TIMEOUT_EN
   ,
   output logic             timeout_hit_o
`endif
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)           cnt_d = '0;
      else if (cnt_q != '1)  cnt_d = cnt_q + 1'b1;
   end

   // The count starts at 0 in a stage's first cycle, so cnt == B-1 marks
   // the B-th (final) cycle of a budgeted stage.
   assign budget_hit_o = (budget_i != '0) && (cnt_q == budget_i - 1'b1);

`ifdef SEQ_TIMEOUT_EN
   assign timeout_hit_o = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

endmodule

// File: rtl/cnn_stage_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_stage_sequencer
// Run-time sequencer for a chain of CNN pipeline stages. On start, all stage
// resets are asserted for one FLUSH cycle, then stages are released one at a
// time; each advances on its done pulse or when its cycle budget expires.
// Optional macro: SEQ_TIMEOUT_EN enables a watchdog for done-driven stages.
//   clk, reset     clock, asynchronous active-high reset
//   start          begin a sequence (sampled in IDLE only)
//   abort          cancel the sequence, every stage back to reset
//   stage_budget   per-stage budget, stage i at [i*CNT_W +: CNT_W], 0 = wait done
//   stage_done     per-stage completion, honoured only for the active stage
//   stage_rst      per-stage reset, active-high
//   stage_en       one-hot enable of the active stage
//   cur_stage      active stage index
//   busy           sequence in progress (FLUSH or RUN)
//   done           one-cycle pulse after the last stage completes
//   err            sticky watchdog error (always 0 without SEQ_TIMEOUT_EN)
//
// Handshake: stage_done[i] is a level sampled once per clock while stage i is
// active; a high sample completes the stage, and the sequencer moves on in the
// following cycle. stage_done of inactive stages is ignored.
// -----------------------------------------------------------------------------
module cnn_stage_sequencer
   import cnn_seq_pkg::*;
#(
   parameter int NUM_STAGES = 9,
   parameter int CNT_W      = CNT_W_DEFAULT
`ifdef SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT    = (1 << CNT_W) - 1
`endif
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          abort,
   input  logic [NUM_STAGES*CNT_W-1:0]   stage_budget,
   input  logic [NUM_STAGES-1:0]         stage_done,
   output logic [NUM_STAGES-1:0]         stage_rst,
   output logic [NUM_STAGES-1:0]         stage_en,
   output logic [$clog2(NUM_STAGES):0]   cur_stage,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int IDX_W = $clog2(NUM_STAGES) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   seq_state_t              state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_STAGES-1:0]   rst_q, rst_d;
   logic [CNT_W-1:0]        cur_budget;
   logic                    cur_done;
   logic                    budget_hit;
   logic                    complete;
   logic                    wd_trip;
   logic                    cnt_clear;

   // Select the active stage's budget and done bit.
   always_comb begin
      cur_budget = '0;
      cur_done   = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_budget = stage_budget[i*CNT_W +: CNT_W];
            cur_done   = stage_done[i];
         end
      end
   end

   assign complete  = (state_q == RUN) && (cur_done || budget_hit);
   // Restart counting whenever a new stage begins or no stage is running.
   assign cnt_clear = (state_q != RUN) || complete;

`ifdef SEQ_TIMEOUT_EN
   logic timeout_hit;
   logic err_q, err_d;

   stage_cycle_counter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_cnt (
      .clk           (clk),
      .reset         (reset),
      .clear_i       (cnt_clear),
      .budget_i      (cur_budget),
      .budget_hit_o  (budget_hit),
      .timeout_hit_o (timeout_hit)
   );

   assign wd_trip = (state_q == RUN) && (cur_budget == '0) && timeout_hit && !cur_done;
   assign err     = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   // Sticky until the next accepted start.
   always_comb begin
      err_d = err_q;
      if (!abort && state_q == IDLE && start) err_d = 1'b0;
      else if (!abort && wd_trip)             err_d = 1'b1;
   end
`else
   stage_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (cnt_clear),
      .budget_i     (cur_budget),
      .budget_hit_o (budget_hit)
   );

   assign wd_trip = 1'b0;
   assign err     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rst_q   <= '1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
      end
   end

   // Next-state logic. Stage resets are registered so that released stages
   // stay released after DONE until the next start flushes them.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      if (abort) begin
         state_d = IDLE;
         idx_d   = '0;
         rst_d   = '1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = FLUSH;
                  idx_d   = '0;
                  rst_d   = '1;
               end
            end
            FLUSH: begin
               state_d  = RUN;
               idx_d    = '0;
               rst_d[0] = 1'b0;
            end
            RUN: begin
               if (wd_trip) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  rst_d   = '1;
               end else if (complete) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = DONE;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                     for (int i = 0; i < NUM_STAGES; i++) begin
                        if (IDX_W'(i) == idx_q + 1'b1) rst_d[i] = 1'b0;
                     end
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output decode
   always_comb begin
      stage_en = '0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         FLUSH: busy = 1'b1;
         RUN: begin
            busy = 1'b1;
            for (int i = 0; i < NUM_STAGES; i++) begin
               if (idx_q == IDX_W'(i)) stage_en[i] = 1'b1;
            end
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign stage_rst = rst_q;
   assign cur_stage = idx_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cnn_stage_sequencer
// Directed bench for a 3-stage sequencer with 8-bit budgets. Inputs are
// driven 1 ns after each rising edge and outputs sampled at the same point,
// so each "cycle" below is the interval between two rising edges.
// -----------------------------------------------------------------------------
module tb_cnn_stage_sequencer;

   localparam int NS = 3;
   localparam int CW = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [NS*CW-1:0] stage_budget;
   logic [NS-1:0]    stage_done;
   logic [NS-1:0]    stage_rst;
   logic [NS-1:0]    stage_en;
   logic [2:0]       cur_stage;
   logic             busy;
   logic             done;
   logic             err;

   int n_checks = 0;
   int n_errors = 0;

   cnn_stage_sequencer #(
      .NUM_STAGES (NS),
      .CNT_W      (CW)
`ifdef SEQ_TIMEOUT_EN
      ,
      .TIMEOUT    (8)
`endif
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .stage_budget (stage_budget),
      .stage_done   (stage_done),
      .stage_rst    (stage_rst),
      .stage_en     (stage_en),
      .cur_stage    (cur_stage),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_budgets(input int b0, input int b1, input int b2);
      stage_budget = {CW'(b2), CW'(b1), CW'(b0)};
   endtask

   // Idle/reset-like outputs: resets as given, nothing enabled or busy.
   task automatic check_idle(input string tag, input logic [NS-1:0] exp_rst);
      check_val({tag, "_rst"},  stage_rst, exp_rst);
      check_val({tag, "_en"},   stage_en, 0);
      check_val({tag, "_cur"},  cur_stage, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
   endtask

   // Pulse start and check the single FLUSH cycle.
   task automatic start_seq(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val({tag, "_flush_rst"},  stage_rst, 3'b111);
      check_val({tag, "_flush_en"},   stage_en, 0);
      check_val({tag, "_flush_busy"}, busy, 1);
      check_val({tag, "_flush_cur"},  cur_stage, 0);
      check_val({tag, "_flush_err"},  err, 0);
   endtask

   // Expect stage s active for ncyc cycles. stage_done[s] is raised in the
   // cycle k == done_at; at k == junk_at a stray start and stage_done[2] are
   // driven and must have no effect.
   task automatic run_stage(input string tag, input int s, input int ncyc,
                            input int done_at, input int junk_at);
      logic [NS-1:0] exp_rst;
      exp_rst = NS'(3'b111 << (s + 1));
      for (int k = 0; k < ncyc; k++) begin
         tick();
         stage_done = '0;
         start      = 1'b0;
         check_val($sformatf("%s_s%0d_c%0d_en", tag, s, k),   stage_en, 32'(1 << s));
         check_val($sformatf("%s_s%0d_c%0d_rst", tag, s, k),  stage_rst, exp_rst);
         check_val($sformatf("%s_s%0d_c%0d_cur", tag, s, k),  cur_stage, s);
         check_val($sformatf("%s_s%0d_c%0d_busy", tag, s, k), busy, 1);
         check_val($sformatf("%s_s%0d_c%0d_done", tag, s, k), done, 0);
         if (k == done_at) stage_done = stage_done | NS'(1 << s);
         if (k == junk_at) begin
            start      = 1'b1;
            stage_done = stage_done | 3'b100;
         end
      end
   endtask

   // DONE pulse for exactly one cycle, stages left released.
   task automatic finish_seq(input string tag);
      tick();
      stage_done = '0;
      start      = 1'b0;
      check_val({tag, "_done_pulse"}, done, 1);
      check_val({tag, "_done_busy"},  busy, 0);
      check_val({tag, "_done_en"},    stage_en, 0);
      check_val({tag, "_done_rst"},   stage_rst, 3'b000);
      tick();
      check_idle({tag, "_after"}, 3'b000);
   endtask

   initial begin
      bit saw_done;

      // Reset
      reset        = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      stage_done   = '0;
      stage_budget = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_idle("reset", 3'b111);
      check_val("reset_err", err, 0);
      tick();
      check_idle("reset_hold", 3'b111);

      // Budgets {4,2,3}: 4, 2 and 3 active cycles, DONE 10 edges after FLUSH.
      set_budgets(4, 2, 3);
      start_seq("bud");
      run_stage("bud", 0, 4, -1, -1);
      run_stage("bud", 1, 2, -1, -1);
      run_stage("bud", 2, 3, -1, -1);
      finish_seq("bud");
      repeat (3) tick();
      check_idle("bud_idle_hold", 3'b000);

      // Done-driven: stage_done at cnt=5 gives 6 active cycles per stage.
      set_budgets(0, 0, 0);
      start_seq("dd");
      run_stage("dd", 0, 6, 5, -1);
      run_stage("dd", 1, 6, 5, -1);
      run_stage("dd", 2, 6, 5, -1);
      finish_seq("dd");

      // Budget 10 with stage_done at cnt=3: stage 0 leaves after 4 cycles.
      set_budgets(10, 1, 1);
      start_seq("early");
      run_stage("early", 0, 4, 3, -1);
      run_stage("early", 1, 1, -1, -1);
      run_stage("early", 2, 1, -1, -1);
      finish_seq("early");

      // Abort in the second cycle of stage 1.
      set_budgets(2, 5, 2);
      start_seq("abort");
      run_stage("abort", 0, 2, -1, -1);
      run_stage("abort", 1, 2, -1, -1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_idle("abort_next", 3'b111);
      saw_done = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      check_val("abort_no_done", saw_done, 0);
      check_idle("abort_idle", 3'b111);

      // abort and start together in IDLE: abort wins.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check_idle("abort_vs_start", 3'b111);
      tick();
      check_idle("abort_vs_start_2", 3'b111);

      // Stray start and stage_done[2] during stage 0: timing unchanged.
      set_budgets(4, 2, 3);
      start_seq("junk");
      run_stage("junk", 0, 4, -1, 1);
      run_stage("junk", 1, 2, -1, -1);
      run_stage("junk", 2, 3, -1, -1);
      finish_seq("junk");

      // Asynchronous reset in the middle of stage 1.
      start_seq("arst");
      run_stage("arst", 0, 4, -1, -1);
      run_stage("arst", 1, 1, -1, -1);
      #2 reset = 1'b1;
      #1;
      check_idle("arst_now", 3'b111);
      tick();
      reset = 1'b0;
      tick();
      check_idle("arst_after", 3'b111);

`ifdef SEQ_TIMEOUT_EN
      // Watchdog: budget 0, no stage_done, TIMEOUT 8.
      set_budgets(0, 0, 0);
      start_seq("wd");
      run_stage("wd", 0, 8, -1, -1);
      tick();
      check_idle("wd_trip", 3'b111);
      check_val("wd_err", err, 1);
      repeat (2) tick();
      check_val("wd_err_sticky", err, 1);
      start_seq("wd_restart");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_idle("wd_restart_abort", 3'b111);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
